// File: rtl/zc_pkg.sv
// -----------------------------------------------------------------------------
// zc_pkg
// Shared types for the zero-crossing period meter.
//   zc_state_e : lock state of the rising-edge detector
//   zc_class_e : hysteresis classification of one sample (HI / LO / MID)
//   zc_next_state() : state transition for one valid, classified sample
// -----------------------------------------------------------------------------
package zc_pkg;

  localparam int unsigned ZC_DATA_W = 16;
  // Wide enough for a period count of up to 2**4 = 16 periods per average.
  localparam int unsigned ZC_PCNT_W = 5;

  typedef enum logic [1:0] {
    ST_UNLOCK = 2'd0,
    ST_LOW    = 2'd1,
    ST_HIGH   = 2'd2
  } zc_state_e;

  typedef enum logic [1:0] {
    CLS_MID = 2'd0,
    CLS_LO  = 2'd1,
    CLS_HI  = 2'd2
  } zc_class_e;

  // A HI sample seen in ST_LOW is the rising event; only LO samples can arm
  // the detector, so HI samples while unlocked are ignored.
  function automatic zc_state_e zc_next_state(input zc_state_e st,
                                              input zc_class_e cls);
    zc_state_e nxt;
    nxt = st;
    case (st)
      ST_UNLOCK: if (cls == CLS_LO) nxt = ST_LOW;
      ST_LOW:    if (cls == CLS_HI) nxt = ST_HIGH;
      ST_HIGH:   if (cls == CLS_LO) nxt = ST_LOW;
      default:   nxt = ST_UNLOCK;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/zc_schmitt.sv
// -----------------------------------------------------------------------------
// zc_schmitt
// Combinational hysteresis classifier for one signed sample.
//   i_data : signed 16-bit sample
//   o_cls  : CLS_HI if i_data >= HYST, CLS_LO if i_data <= -HYST, else CLS_MID
// -----------------------------------------------------------------------------
module zc_schmitt
  import zc_pkg::*;
#(
  parameter logic signed [ZC_DATA_W-1:0] HYST = 16'sd256
) (
  input  logic signed [ZC_DATA_W-1:0] i_data,
  output zc_class_e                   o_cls
);

  // HYST is limited to 1..16383, so its negation always fits in 16 bits.
  localparam logic signed [ZC_DATA_W-1:0] NEG_HYST = -HYST;

  always_comb begin
    // NOTE: default assignment first so every path drives o_cls; a missing
    // branch in always_comb would otherwise infer a latch.
    o_cls = CLS_MID;
    if (i_data >= HYST) begin
      o_cls = CLS_HI;
    end else if (i_data <= NEG_HYST) begin
      o_cls = CLS_LO;
    end
  end

endmodule

// File: rtl/zero_cross_period_meter.sv
// -----------------------------------------------------------------------------
// zero_cross_period_meter
// Measures the period of a filtered signal (in valid samples) between
// hysteresis-qualified rising events and reports the average of 2**AVG_LOG2
// consecutive accepted periods.
//   clock          : sole clock, rising edge
//   reset          : synchronous, active-high
//   data_i         : signed 16-bit filtered sample
//   valid_i        : one-cycle strobe qualifying data_i
//   period_o       : averaged period in samples, held between updates
//   period_valid_o : one-cycle pulse on each period_o update
//   no_signal_o    : high while no valid period measurement is held
// -----------------------------------------------------------------------------
module zero_cross_period_meter
  import zc_pkg::*;
#(
  parameter logic signed [15:0] HYST       = 16'sd256,
  parameter int unsigned        PERIOD_W   = 24,
  parameter int unsigned        MIN_PERIOD = 4,
  parameter int unsigned        MAX_PERIOD = 2**PERIOD_W - 1,
  parameter int unsigned        AVG_LOG2   = 2
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic signed [ZC_DATA_W-1:0] data_i,
  input  logic                        valid_i,
  output logic [PERIOD_W-1:0]         period_o,
  output logic                        period_valid_o,
  output logic                        no_signal_o
);

  // Sum of 2**AVG_LOG2 periods, each below 2**PERIOD_W, cannot overflow.
  localparam int unsigned              ACC_W   = PERIOD_W + AVG_LOG2;
  localparam logic [PERIOD_W-1:0]      LP_MIN  = PERIOD_W'(MIN_PERIOD);
  localparam logic [PERIOD_W-1:0]      LP_MAX  = PERIOD_W'(MAX_PERIOD);
  localparam logic [PERIOD_W-1:0]      LP_ONE  = PERIOD_W'(1);
  localparam logic [ZC_PCNT_W-1:0]     LP_LAST = ZC_PCNT_W'((1 << AVG_LOG2) - 1);

  zc_class_e              w_cls;
  zc_state_e              r_state;
  logic [PERIOD_W-1:0]    r_count;
  logic [ACC_W-1:0]       r_acc;
  logic [ZC_PCNT_W-1:0]   r_pcnt;

  logic                   w_running;
  logic                   w_rise;
  logic                   w_timeout;
  logic                   w_accept;
  logic                   w_last;
  logic [ACC_W-1:0]       w_acc_sum;
  logic [PERIOD_W-1:0]    w_avg;

  zc_schmitt #(
    .HYST (HYST)
  ) u_schmitt (
    .i_data (data_i),
    .o_cls  (w_cls)
  );

  // r_count is the number of valid samples since the last accepted rising
  // event, so at the next event it already equals the period P. Zero means
  // the counter has not been started (unlocked or waiting for the first rise).
  assign w_running = (r_count != '0);
  assign w_rise    = (r_state == ST_LOW) && (w_cls == CLS_HI);
  // The counter stops at MAX_PERIOD and never wraps; this check wins over any
  // event carried by the same sample.
  assign w_timeout = w_running && (r_count >= LP_MAX);
  assign w_accept  = w_rise && w_running && (r_count >= LP_MIN);
  assign w_last    = (r_pcnt == LP_LAST);

  // Averaging is a plain right shift of the running sum (truncating).
  assign w_acc_sum = r_acc + ACC_W'(r_count);
  assign w_avg     = PERIOD_W'(w_acc_sum >> AVG_LOG2);

  // NOTE: all state updates use non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state        <= ST_UNLOCK;
      r_count        <= '0;
      r_acc          <= '0;
      r_pcnt         <= '0;
      period_o       <= '0;
      period_valid_o <= 1'b0;
      no_signal_o    <= 1'b1;
    end else begin
      period_valid_o <= 1'b0;
      if (valid_i) begin
        if (w_timeout) begin
          // Lost lock: drop the partial average but keep the last period_o.
          r_state     <= ST_UNLOCK;
          r_count     <= '0;
          r_acc       <= '0;
          r_pcnt      <= '0;
          no_signal_o <= 1'b1;
        end else begin
          // A rejected (too short) rise still moves the FSM to ST_HIGH.
          r_state <= zc_next_state(r_state, w_cls);
          if (w_rise && !w_running) begin
            // First rise after unlock only starts the measurement.
            r_count <= LP_ONE;
          end else if (w_accept) begin
            r_count <= LP_ONE;
            if (w_last) begin
              period_o       <= w_avg;
              period_valid_o <= 1'b1;
              no_signal_o    <= 1'b0;
              r_acc          <= '0;
              r_pcnt         <= '0;
            end else begin
              r_acc  <= w_acc_sum;
              r_pcnt <= r_pcnt + 1'b1;
            end
          end else if (w_running) begin
            r_count <= r_count + 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_zero_cross_period_meter.sv
// -----------------------------------------------------------------------------
// tb_zero_cross_period_meter
// Self-checking bench: sample streams are built as queues, driven with random
// valid_i gaps, and compared sample by sample against an index-based model of
// the period meter, plus fixed expectations for the scenario-specific outcomes.
// -----------------------------------------------------------------------------
module tb_zero_cross_period_meter;

  localparam int HYST_V = 256;
  localparam int MIN_P  = 4;
  localparam int MAX_P  = 1000;
  localparam int NAVG   = 4;
  localparam int PW     = 24;

  logic                 clock   = 1'b0;
  logic                 reset   = 1'b1;
  logic                 valid_i = 1'b0;
  logic signed [15:0]   data_i  = '0;
  logic [PW-1:0]        period_o;
  logic                 period_valid_o;
  logic                 no_signal_o;

  int checks   = 0;
  int failures = 0;

  zero_cross_period_meter #(
    .HYST       (16'sd256),
    .PERIOD_W   (PW),
    .MIN_PERIOD (MIN_P),
    .MAX_PERIOD (MAX_P),
    .AVG_LOG2   (2)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .data_i         (data_i),
    .valid_i        (valid_i),
    .period_o       (period_o),
    .period_valid_o (period_valid_o),
    .no_signal_o    (no_signal_o)
  );

  always #5 clock = ~clock;

  // ---------------------------------------------------------------------------
  // Reference model: works on absolute sample indices. A rising event is a HI
  // sample whose last decisive (non-MID) sample was LO; the period is the index
  // difference to the last accepted rise.
  // ---------------------------------------------------------------------------
  int            m_idx;
  int            m_level;   // 0 = unarmed since unlock, 1 = LO, 2 = HI
  int            m_rise;    // index of last accepted rise, -1 if none
  int            m_periods[$];
  bit            exp_pv;
  logic [PW-1:0] exp_po;
  bit            exp_ns;

  bit            obs_pv;
  logic [PW-1:0] obs_po;
  logic          obs_ns;
  bit            gap_bad;
  int            max_gap = 0;

  int            wave[$];

  function automatic void model_reset();
    m_idx   = 0;
    m_level = 0;
    m_rise  = -1;
    m_periods.delete();
    exp_pv  = 1'b0;
    exp_po  = '0;
    exp_ns  = 1'b1;
  endfunction

  function automatic void model_step(input int d);
    int p;
    int sum;
    exp_pv = 1'b0;
    if (m_rise >= 0 && (m_idx - m_rise) >= MAX_P) begin
      m_level = 0;
      m_rise  = -1;
      m_periods.delete();
      exp_ns  = 1'b1;
    end else if (d <= -HYST_V) begin
      m_level = 1;
    end else if (d >= HYST_V) begin
      if (m_level == 1) begin
        if (m_rise < 0) begin
          m_rise = m_idx;
        end else begin
          p = m_idx - m_rise;
          if (p >= MIN_P) begin
            m_periods.push_back(p);
            m_rise = m_idx;
            if (m_periods.size() == NAVG) begin
              sum = 0;
              foreach (m_periods[i]) sum += m_periods[i];
              exp_po = PW'(sum / NAVG);
              exp_pv = 1'b1;
              exp_ns = 1'b0;
              m_periods.delete();
            end
          end
        end
      end
      if (m_level != 0) m_level = 2;
    end
    m_idx++;
  endfunction

  // ---------------------------------------------------------------------------
  // Stimulus helpers
  // ---------------------------------------------------------------------------
  function automatic int rand_amp();
    case ($urandom_range(0, 2))
      0:       return HYST_V;
      1:       return 1000;
      default: return int'($urandom_range(HYST_V + 1, 32767));
    endcase
  endfunction

  function automatic void push_run(input int v, input int n);
    for (int i = 0; i < n; i++) wave.push_back(v);
  endfunction

  // One period: HI for p/2 samples, then LO for the rest.
  function automatic void push_period(input int p, input bit fixed_amp);
    int a;
    a = fixed_amp ? 1000 : rand_amp();
    push_run(a, p / 2);
    a = fixed_amp ? 1000 : rand_amp();
    push_run(-a, p - p / 2);
  endfunction

  // Drive one valid sample, capture outputs one edge later, then idle for a
  // random number of cycles with junk data and valid_i low.
  task automatic send(input logic signed [15:0] d);
    int gap;
    data_i  = d;
    valid_i = 1'b1;
    @(posedge clock); #1;
    valid_i = 1'b0;
    data_i  = 16'($urandom);
    model_step(int'(d));
    obs_pv  = period_valid_o;
    obs_po  = period_o;
    obs_ns  = no_signal_o;
    gap_bad = 1'b0;
    gap     = int'($urandom_range(0, max_gap));
    repeat (gap) begin
      @(posedge clock); #1;
      data_i = 16'($urandom);
      if (period_valid_o !== 1'b0 || period_o !== obs_po || no_signal_o !== obs_ns)
        gap_bad = 1'b1;
    end
  endtask

  task automatic do_reset();
    reset   = 1'b1;
    valid_i = 1'b1;
    repeat (3) begin
      data_i = 16'($urandom);
      @(posedge clock); #1;
    end
    reset   = 1'b0;
    valid_i = 1'b0;
    model_reset();
  endtask

  // ---------------------------------------------------------------------------
  // Tests
  // ---------------------------------------------------------------------------
  task automatic test_reset();
    reset   = 1'b1;
    valid_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      data_i = (i % 2 == 1) ? 16'sd2000 : -16'sd2000;
      @(posedge clock); #1;
      checks++;
      if (period_o !== '0 || period_valid_o !== 1'b0 || no_signal_o !== 1'b1) begin
        failures++;
        $display("FAIL reset_values cyc=%0d got po=%0d pv=%b ns=%b want po=0 pv=0 ns=1",
                 i, period_o, period_valid_o, no_signal_o);
      end
    end
    reset   = 1'b0;
    valid_i = 1'b0;
    model_reset();
  endtask

  task automatic test_square();
    int   pulses = 0;
    int   first  = -1;
    logic ns_before = 1'bx;
    do_reset();
    max_gap = 2;
    wave.delete();
    push_run(-1000, 10);
    repeat (10) push_period(20, 1'b1);
    foreach (wave[i]) begin
      send(16'(wave[i]));
      checks++;
      if (obs_pv !== exp_pv || obs_po !== exp_po || obs_ns !== exp_ns || gap_bad) begin
        failures++;
        $display("FAIL square idx=%0d got pv=%b po=%0d ns=%b want pv=%b po=%0d ns=%b gap_bad=%b",
                 i, obs_pv, obs_po, obs_ns, exp_pv, exp_po, exp_ns, gap_bad);
      end
      if (obs_pv) begin
        pulses++;
        if (first < 0) first = i;
      end
      if (i == 89) ns_before = obs_ns;
    end
    checks++;
    if (first != 90) begin
      failures++;
      $display("FAIL square_first_pulse got idx=%0d want idx=90 (5th rise)", first);
    end
    checks++;
    if (pulses != 2) begin
      failures++;
      $display("FAIL square_pulse_count got %0d want 2", pulses);
    end
    checks++;
    if (ns_before !== 1'b1 || no_signal_o !== 1'b0 || period_o !== PW'(20)) begin
      failures++;
      $display("FAIL square_outputs got ns_before=%b ns=%b po=%0d want 1 0 20",
               ns_before, no_signal_o, period_o);
    end
  endtask

  task automatic test_alt_periods();
    int pulses = 0;
    do_reset();
    max_gap = 1;
    wave.delete();
    push_run(-rand_amp(), 10);
    for (int k = 0; k < 17; k++) push_period((k % 2 == 0) ? 19 : 21, 1'b0);
    foreach (wave[i]) begin
      send(16'(wave[i]));
      checks++;
      if (obs_pv !== exp_pv || obs_po !== exp_po || obs_ns !== exp_ns || gap_bad) begin
        failures++;
        $display("FAIL alt idx=%0d got pv=%b po=%0d ns=%b want pv=%b po=%0d ns=%b gap_bad=%b",
                 i, obs_pv, obs_po, obs_ns, exp_pv, exp_po, exp_ns, gap_bad);
      end
      if (obs_pv) begin
        pulses++;
        checks++;
        if (obs_po !== PW'(20)) begin
          failures++;
          $display("FAIL alt_avg idx=%0d got po=%0d want 20", i, obs_po);
        end
      end
    end
    checks++;
    if (pulses != 4) begin
      failures++;
      $display("FAIL alt_pulse_count got %0d want 4", pulses);
    end
  endtask

  task automatic test_no_signal();
    int v;
    int bad = 0;
    do_reset();
    max_gap = 0;
    for (int i = 0; i < 1200; i++) begin
      v = $rtoi(200.0 * $sin(6.283185307 * real'(i) / 20.0));
      if (i % 50 == 7)  v = 255;
      if (i % 50 == 32) v = -255;
      send(16'(v));
      checks++;
      if (obs_pv !== exp_pv || obs_po !== exp_po || obs_ns !== exp_ns) begin
        failures++;
        $display("FAIL quiet idx=%0d got pv=%b po=%0d ns=%b want pv=%b po=%0d ns=%b",
                 i, obs_pv, obs_po, obs_ns, exp_pv, exp_po, exp_ns);
      end
      if (obs_pv !== 1'b0 || obs_ns !== 1'b1) bad++;
    end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL quiet_no_lock got %0d samples with pulse or ns=0 want 0", bad);
    end
  endtask

  task automatic test_timeout();
    int pulses_lock = 0;
    int pulses_zero = 0;
    int ns_rise     = -1;
    int first_relock = -1;
    do_reset();
    max_gap = 0;
    wave.delete();
    push_run(-1000, 10);
    repeat (5) push_period(20, 1'b1);
    push_run(0, 1005);
    foreach (wave[i]) begin
      send(16'(wave[i]));
      checks++;
      if (obs_pv !== exp_pv || obs_po !== exp_po || obs_ns !== exp_ns) begin
        failures++;
        $display("FAIL timeout idx=%0d got pv=%b po=%0d ns=%b want pv=%b po=%0d ns=%b",
                 i, obs_pv, obs_po, obs_ns, exp_pv, exp_po, exp_ns);
      end
      if (i < 110 && obs_pv) pulses_lock++;
      if (i >= 110) begin
        if (obs_pv) pulses_zero++;
        if (obs_ns === 1'b1 && ns_rise < 0) ns_rise = i;
      end
    end
    checks++;
    if (pulses_lock != 1 || pulses_zero != 0) begin
      failures++;
      $display("FAIL timeout_pulses got lock=%0d idle=%0d want 1 0", pulses_lock, pulses_zero);
    end
    // Last rise at index 90, so the timeout lands 1000 samples later.
    checks++;
    if (ns_rise != 1090) begin
      failures++;
      $display("FAIL timeout_instant got idx=%0d want 1090", ns_rise);
    end
    checks++;
    if (period_o !== PW'(20) || no_signal_o !== 1'b1) begin
      failures++;
      $display("FAIL timeout_hold got po=%0d ns=%b want po=20 ns=1", period_o, no_signal_o);
    end
    // Relock after timeout needs a full fresh set of rising events.
    wave.delete();
    push_run(-1000, 10);
    repeat (5) push_period(20, 1'b1);
    foreach (wave[i]) begin
      send(16'(wave[i]));
      checks++;
      if (obs_pv !== exp_pv || obs_po !== exp_po || obs_ns !== exp_ns) begin
        failures++;
        $display("FAIL relock idx=%0d got pv=%b po=%0d ns=%b want pv=%b po=%0d ns=%b",
                 i, obs_pv, obs_po, obs_ns, exp_pv, exp_po, exp_ns);
      end
      if (obs_pv && first_relock < 0) first_relock = i;
    end
    checks++;
    if (first_relock != 90) begin
      failures++;
      $display("FAIL relock_first_pulse got idx=%0d want 90", first_relock);
    end
  endtask

  task automatic test_spike();
    int pulses = 0;
    do_reset();
    max_gap = 1;
    wave.delete();
    push_run(-1000, 10);
    for (int k = 0; k < 10; k++) begin
      if (k == 3 || k == 7) begin
        // Real rise, then a one-sample LO,HI,LO glitch two samples later.
        push_run(1000, 1);
        push_run(-1000, 1);
        push_run(1000, 1);
        push_run(-1000, 17);
      end else begin
        push_period(20, 1'b1);
      end
    end
    foreach (wave[i]) begin
      send(16'(wave[i]));
      checks++;
      if (obs_pv !== exp_pv || obs_po !== exp_po || obs_ns !== exp_ns || gap_bad) begin
        failures++;
        $display("FAIL spike idx=%0d got pv=%b po=%0d ns=%b want pv=%b po=%0d ns=%b gap_bad=%b",
                 i, obs_pv, obs_po, obs_ns, exp_pv, exp_po, exp_ns, gap_bad);
      end
      if (obs_pv) pulses++;
    end
    checks++;
    if (pulses != 2 || period_o !== PW'(20)) begin
      failures++;
      $display("FAIL spike_result got pulses=%0d po=%0d want pulses=2 po=20", pulses, period_o);
    end
  endtask

  task automatic test_reset_mid();
    int first = -1;
    do_reset();
    max_gap = 1;
    wave.delete();
    push_run(-1000, 10);
    repeat (7) push_period(20, 1'b1);
    push_run(1000, 5);
    foreach (wave[i]) begin
      send(16'(wave[i]));
      checks++;
      if (obs_pv !== exp_pv || obs_po !== exp_po || obs_ns !== exp_ns || gap_bad) begin
        failures++;
        $display("FAIL premid idx=%0d got pv=%b po=%0d ns=%b want pv=%b po=%0d ns=%b gap_bad=%b",
                 i, obs_pv, obs_po, obs_ns, exp_pv, exp_po, exp_ns, gap_bad);
      end
    end
    // Three periods are now partially accumulated; reset with valid_i high.
    reset   = 1'b1;
    valid_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      data_i = (i == 1) ? 16'sd3000 : -16'sd3000;
      @(posedge clock); #1;
      checks++;
      if (period_o !== '0 || period_valid_o !== 1'b0 || no_signal_o !== 1'b1) begin
        failures++;
        $display("FAIL midreset_values cyc=%0d got po=%0d pv=%b ns=%b want po=0 pv=0 ns=1",
                 i, period_o, period_valid_o, no_signal_o);
      end
    end
    reset   = 1'b0;
    valid_i = 1'b0;
    model_reset();
    wave.delete();
    push_run(-1000, 10);
    repeat (5) push_period(20, 1'b1);
    foreach (wave[i]) begin
      send(16'(wave[i]));
      checks++;
      if (obs_pv !== exp_pv || obs_po !== exp_po || obs_ns !== exp_ns || gap_bad) begin
        failures++;
        $display("FAIL postmid idx=%0d got pv=%b po=%0d ns=%b want pv=%b po=%0d ns=%b gap_bad=%b",
                 i, obs_pv, obs_po, obs_ns, exp_pv, exp_po, exp_ns, gap_bad);
      end
      if (obs_pv && first < 0) first = i;
    end
    checks++;
    if (first != 90) begin
      failures++;
      $display("FAIL midreset_relock got first pulse idx=%0d want 90", first);
    end
  endtask

  task automatic test_random();
    int p;
    int v;
    int n;
    do_reset();
    max_gap = 3;
    wave.delete();
    push_run(-rand_amp(), 8);
    for (int k = 0; k < 40; k++) begin
      p = int'($urandom_range(2, 60));
      push_period(p, 1'b0);
    end
    // Sprinkle MID samples over the stream; the model decides their effect.
    n = wave.size();
    for (int i = 0; i < n; i++) begin
      if ($urandom_range(0, 9) == 0) begin
        v = int'($urandom_range(0, 510)) - 255;
        wave[i] = v;
      end
    end
    foreach (wave[i]) begin
      send(16'(wave[i]));
      checks++;
      if (obs_pv !== exp_pv || obs_po !== exp_po || obs_ns !== exp_ns || gap_bad) begin
        failures++;
        $display("FAIL random idx=%0d d=%0d got pv=%b po=%0d ns=%b want pv=%b po=%0d ns=%b gap_bad=%b",
                 i, wave[i], obs_pv, obs_po, obs_ns, exp_pv, exp_po, exp_ns, gap_bad);
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_square();
    test_alt_periods();
    test_no_signal();
    test_timeout();
    test_spike();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog simulation time limit reached checks=%0d", checks);
    $fatal(1);
  end

endmodule
